// File: rtl/oled_pixel_streamer.sv
// Streams RGB565 frames to an SPI OLED panel: a 6-byte window command, then two
// data bytes per pixel in row-major scan order, repeated while enable is high.
module oled_pixel_streamer #(
  parameter int SPI_DIV   = 4,
  parameter int FETCH_LAT = 2,
  parameter int COLS      = 96,
  parameter int ROWS      = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] pixel_data,
  output logic [12:0] pixel_index,
  output logic        frame_begin,
  output logic        cs_n,
  output logic        sclk,
  output logic        sdin,
  output logic        d_cn
);
  localparam int DW = $clog2(SPI_DIV + 1);
  localparam int FW = $clog2(FETCH_LAT + 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(SPI_DIV - 1);
  localparam logic [FW-1:0] FETCH_LAST = FW'(FETCH_LAT);
  localparam logic [12:0]   PIX_LAST   = 13'(COLS * ROWS - 1);

  typedef enum logic [2:0] {IDLE, CMD, FETCH, SEND_HI, SEND_LO} state_t;

  state_t        state, state_nx;
  logic [DW-1:0] div_cnt, div_cnt_nx;
  logic [FW-1:0] fetch_cnt, fetch_cnt_nx;
  logic [2:0]    bit_cnt, bit_cnt_nx;
  logic [2:0]    byte_cnt, byte_cnt_nx;
  logic [6:0]    shift, shift_nx;
  logic [7:0]    pix_lo, pix_lo_nx;
  logic [12:0]   pixel_index_nx;
  logic          frame_begin_nx, cs_n_nx, sclk_nx, sdin_nx, d_cn_nx;
  logic          half_end, byte_end, start, load_en;
  logic [7:0]    load_byte;

  // Column window 0..COLS-1, row window 0..ROWS-1.
  function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    cmd_byte = 8'h15;
      3'd1:    cmd_byte = 8'h00;
      3'd2:    cmd_byte = 8'(COLS - 1);
      3'd3:    cmd_byte = 8'h75;
      3'd4:    cmd_byte = 8'h00;
      default: cmd_byte = 8'(ROWS - 1);
    endcase
  endfunction

  assign half_end = (div_cnt == DIV_LAST);
  assign byte_end = half_end && sclk && (bit_cnt == 3'd7);

  always_comb begin
    // NOTE: every variable gets its hold value first so no branch can infer a latch.
    state_nx       = state;
    div_cnt_nx     = div_cnt;
    fetch_cnt_nx   = '0;
    bit_cnt_nx     = bit_cnt;
    byte_cnt_nx    = byte_cnt;
    shift_nx       = shift;
    pix_lo_nx      = pix_lo;
    pixel_index_nx = pixel_index;
    frame_begin_nx = 1'b0;
    cs_n_nx        = cs_n;
    sclk_nx        = sclk;
    sdin_nx        = sdin;
    d_cn_nx        = d_cn;
    start          = 1'b0;
    load_en        = 1'b0;
    load_byte      = 8'h00;

    // Bit engine: sclk low for the first half of a bit, high for the second.
    if (state inside {CMD, SEND_HI, SEND_LO}) begin
      div_cnt_nx = half_end ? '0 : div_cnt + 1'b1;
      if (half_end && !sclk) begin
        sclk_nx = 1'b1;
      end else if (half_end && !byte_end) begin
        sclk_nx    = 1'b0;
        sdin_nx    = shift[6];
        shift_nx   = {shift[5:0], 1'b0};
        bit_cnt_nx = bit_cnt + 3'd1;
      end
    end

    case (state)
      IDLE: start = enable;
      CMD: begin
        if (byte_end) begin
          if (byte_cnt == 3'd5) begin
            state_nx = FETCH;
          end else begin
            byte_cnt_nx = byte_cnt + 3'd1;
            load_en     = 1'b1;
            load_byte   = cmd_byte(byte_cnt + 3'd1);
          end
        end
      end
      FETCH: begin
        // The high byte goes straight into the shifter; together with pix_lo
        // this holds the whole 16-bit word sampled at the latch point.
        if (fetch_cnt == FETCH_LAST) begin
          pix_lo_nx = pixel_data[7:0];
          load_en   = 1'b1;
          load_byte = pixel_data[15:8];
          d_cn_nx   = 1'b1;
          state_nx  = SEND_HI;
        end else begin
          fetch_cnt_nx = fetch_cnt + 1'b1;
        end
      end
      SEND_HI: begin
        if (byte_end) begin
          load_en   = 1'b1;
          load_byte = pix_lo;
          state_nx  = SEND_LO;
        end
      end
      SEND_LO: begin
        if (byte_end) begin
          if (pixel_index != PIX_LAST) begin
            pixel_index_nx = pixel_index + 13'd1;
            state_nx       = FETCH;
          end else begin
            pixel_index_nx = '0;
            if (enable) begin
              start = 1'b1;
            end else begin
              state_nx = IDLE;
              cs_n_nx  = 1'b1;
              d_cn_nx  = 1'b0;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    if (start) begin
      state_nx       = CMD;
      frame_begin_nx = 1'b1;
      cs_n_nx        = 1'b0;
      d_cn_nx        = 1'b0;
      byte_cnt_nx    = '0;
      load_en        = 1'b1;
      load_byte      = cmd_byte(3'd0);
    end

    if (load_en) begin
      sclk_nx    = 1'b0;
      sdin_nx    = load_byte[7];
      shift_nx   = load_byte[6:0];
      bit_cnt_nx = '0;
      div_cnt_nx = '0;
    end
  end

  // NOTE: non-blocking assignments make all register updates order-independent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      div_cnt     <= '0;
      fetch_cnt   <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      shift       <= '0;
      pix_lo      <= '0;
      pixel_index <= '0;
      frame_begin <= 1'b0;
      cs_n        <= 1'b1;
      sclk        <= 1'b1;
      sdin        <= 1'b0;
      d_cn        <= 1'b0;
    end else begin
      state       <= state_nx;
      div_cnt     <= div_cnt_nx;
      fetch_cnt   <= fetch_cnt_nx;
      bit_cnt     <= bit_cnt_nx;
      byte_cnt    <= byte_cnt_nx;
      shift       <= shift_nx;
      pix_lo      <= pix_lo_nx;
      pixel_index <= pixel_index_nx;
      frame_begin <= frame_begin_nx;
      cs_n        <= cs_n_nx;
      sclk        <= sclk_nx;
      sdin        <= sdin_nx;
      d_cn        <= d_cn_nx;
    end
  end
endmodule

// File: tb/tb_oled_pixel_streamer.sv
// Self-checking bench: an SPI receiver decodes the byte stream and compares it
// with frames built from the panel rules and a random pixel memory.
module tb_oled_pixel_streamer;
  localparam int SPI_DIV   = 4;
  localparam int FETCH_LAT = 3;
  localparam int COLS      = 8;
  localparam int ROWS      = 4;
  localparam int NPIX      = COLS * ROWS;
  localparam int FRAME_LEN = 6 * 16 * SPI_DIV + NPIX * (FETCH_LAT + 1 + 32 * SPI_DIV);
  localparam int FRAME_BYTES = 6 + 2 * NPIX;

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic [15:0] pixel_data = '0;
  logic [12:0] pixel_index;
  logic frame_begin, cs_n, sclk, sdin, d_cn;

  logic en_full = 1'b0;
  logic [15:0] pixel_data_full = '0;
  logic [12:0] pixel_index_full;
  logic frame_begin_full, cs_n_full, sclk_full, sdin_full, d_cn_full;

  always #5 clk = ~clk;

  oled_pixel_streamer #(.SPI_DIV(SPI_DIV), .FETCH_LAT(FETCH_LAT), .COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pixel_data(pixel_data),
    .pixel_index(pixel_index), .frame_begin(frame_begin), .cs_n(cs_n),
    .sclk(sclk), .sdin(sdin), .d_cn(d_cn)
  );

  // Full 96x64 panel geometry, used for the command window bytes.
  oled_pixel_streamer #(.SPI_DIV(1), .FETCH_LAT(2)) dut_full (
    .clk(clk), .rst_n(rst_n), .enable(en_full), .pixel_data(pixel_data_full),
    .pixel_index(pixel_index_full), .frame_begin(frame_begin_full), .cs_n(cs_n_full),
    .sclk(sclk_full), .sdin(sdin_full), .d_cn(d_cn_full)
  );

  int n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [15:0] mem [NPIX];
  logic [7:0]  cmd_tab [6];
  logic [8:0]  exp_q [$];
  logic [8:0]  rx_q [$];
  logic [8:0]  rxf_q [$];
  logic [8:0]  full_exp [10];
  int fb_cyc [$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SPI receiver and protocol monitor for the main instance.
  int rx_bits = 0, run_len = 0;
  int sdin_err = 0, phase_err = 0, dcn_err = 0, idx_err = 0, cs_rise = 0;
  logic [7:0] rx_sh = '0;
  logic rx_dc = 1'b0, prev_sclk = 1'b1, prev_sdin = 1'b0, prev_cs = 1'b1;
  always @(negedge clk) begin
    if (!rst_n) begin
      rx_bits = 0;
      run_len = 0;
    end else begin
      if (frame_begin) fb_cyc.push_back(cyc);
      if (pixel_index >= NPIX) idx_err++;
      if (!prev_cs && cs_n) cs_rise++;
      if (!cs_n) begin
        if (sclk && !prev_sclk) begin
          if (rx_bits == 0) rx_dc = d_cn;
          else if (d_cn != rx_dc) dcn_err++;
          rx_sh = {rx_sh[6:0], sdin};
          rx_bits++;
          if (rx_bits == 8) begin
            rx_q.push_back({rx_dc, rx_sh});
            rx_bits = 0;
          end
        end
        if (sdin != prev_sdin && !(prev_sclk && !sclk)) sdin_err++;
        if (prev_cs) run_len = 1;
        else if (sclk != prev_sclk) begin
          if (!prev_sclk && run_len != SPI_DIV) phase_err++;
          if (prev_sclk && run_len != SPI_DIV && run_len != SPI_DIV + FETCH_LAT + 1) phase_err++;
          run_len = 1;
        end else run_len++;
      end else rx_bits = 0;
    end
    prev_sclk = sclk;
    prev_sdin = sdin;
    prev_cs   = cs_n;
  end

  int rxf_bits = 0, fbf_cnt = 0;
  logic [7:0] rxf_sh = '0;
  logic prevf_sclk = 1'b1;
  always @(negedge clk) begin
    if (rst_n && frame_begin_full) fbf_cnt++;
    if (rst_n && !cs_n_full) begin
      if (sclk_full && !prevf_sclk) begin
        rxf_sh = {rxf_sh[6:0], sdin_full};
        rxf_bits++;
        if (rxf_bits == 8) begin
          rxf_q.push_back({d_cn_full, rxf_sh});
          rxf_bits = 0;
        end
      end
    end else rxf_bits = 0;
    prevf_sclk = sclk_full;
  end

  // Pixel source: the correct word only in the single cycle the panel timing
  // says it is sampled, random noise otherwise.
  initial begin : src_main
    logic [12:0] last_idx;
    int since, valid_at;
    last_idx = '0;
    since = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || pixel_index != last_idx || frame_begin) since = 0;
      else since++;
      last_idx = pixel_index;
      valid_at = (pixel_index == 0) ? 96 * SPI_DIV + FETCH_LAT : FETCH_LAT;
      if (pixel_index < NPIX && since == valid_at) pixel_data = mem[pixel_index];
      else pixel_data = 16'($urandom);
    end
  end

  initial begin : src_full
    forever begin
      @(negedge clk);
      pixel_data_full = {3'b000, pixel_index_full};
    end
  end

  task automatic append_frame(input int nbytes);
    for (int p = 0; p < nbytes; p++) begin
      if (p < 6) exp_q.push_back({1'b0, cmd_tab[p]});
      else if (((p - 6) % 2) == 0) exp_q.push_back({1'b1, mem[(p - 6) / 2][15:8]});
      else exp_q.push_back({1'b1, mem[(p - 6) / 2][7:0]});
    end
  endtask

  task automatic compare_stream(input string tag);
    check($sformatf("%s_nbytes", tag), rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), (i < rx_q.size()) ? rx_q[i] : 9'bx, exp_q[i]);
  endtask

  initial begin : main
    int t, drop_at;
    cmd_tab  = '{8'h15, 8'h00, 8'(COLS - 1), 8'h75, 8'h00, 8'(ROWS - 1)};
    full_exp = '{9'h015, 9'h000, 9'h05F, 9'h075, 9'h000, 9'h03F, 9'h100, 9'h100, 9'h100, 9'h101};
    for (int i = 0; i < NPIX; i++) mem[i] = 16'($urandom);

    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n, 1);
    check("rst_sclk", sclk, 1);
    check("rst_sdin", sdin, 0);
    check("rst_d_cn", d_cn, 0);
    check("rst_pixel_index", pixel_index, 0);
    check("rst_frame_begin", frame_begin, 0);

    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_cs_n", cs_n, 1);
    check("idle_sclk", sclk, 1);
    check("idle_no_frame", fb_cyc.size(), 0);

    // Full-size geometry: window command and the first two pixels.
    en_full = 1'b1;
    t = 0;
    while (rxf_q.size() < 10 && t < 600) begin @(negedge clk); t++; end
    check("full_wait_bytes", rxf_q.size() >= 10, 1);
    for (int i = 0; i < 10; i++)
      check($sformatf("full_byte%0d", i), (i < rxf_q.size()) ? rxf_q[i] : 9'bx, full_exp[i]);
    check("full_frame_begin_cnt", fbf_cnt, 1);
    en_full = 1'b0;

    // One-cycle enable pulse in IDLE: exactly one complete frame.
    rx_q.delete(); exp_q.delete(); fb_cyc.delete(); cs_rise = 0;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    t = 0;
    while (!(cs_n && rx_q.size() >= FRAME_BYTES) && t < FRAME_LEN + 200) begin @(negedge clk); t++; end
    check("pulse_wait_end", cs_n && rx_q.size() >= FRAME_BYTES, 1);
    repeat (50) @(negedge clk);
    append_frame(FRAME_BYTES);
    compare_stream("pulse");
    check("pulse_frame_begin_cnt", fb_cyc.size(), 1);
    check("pulse_cs_rise", cs_rise, 1);
    check("pulse_end_index", pixel_index, 0);

    // Enable held: back-to-back frames, then dropped in the middle of frame 3.
    rx_q.delete(); exp_q.delete(); fb_cyc.delete(); cs_rise = 0;
    drop_at = $urandom_range(NPIX - 2, 1);
    enable = 1'b1;
    t = 0;
    while (fb_cyc.size() < 3 && t < 3 * FRAME_LEN) begin @(negedge clk); t++; end
    check("cont_wait_frame3", fb_cyc.size(), 3);
    t = 0;
    while (pixel_index != drop_at && t < FRAME_LEN) begin @(negedge clk); t++; end
    check("cont_wait_drop", pixel_index, drop_at);
    enable = 1'b0;
    t = 0;
    while (!cs_n && t < FRAME_LEN + 200) begin @(negedge clk); t++; end
    check("cont_wait_end", cs_n, 1);
    repeat (200) @(negedge clk);
    for (int f = 0; f < 3; f++) append_frame(FRAME_BYTES);
    compare_stream("cont");
    check("cont_frame_begin_cnt", fb_cyc.size(), 3);
    check("cont_period_1", (fb_cyc.size() >= 2) ? fb_cyc[1] - fb_cyc[0] : -1, FRAME_LEN);
    check("cont_period_2", (fb_cyc.size() >= 3) ? fb_cyc[2] - fb_cyc[1] : -1, FRAME_LEN);
    check("cont_cs_rise", cs_rise, 1);
    check("cont_end_index", pixel_index, 0);

    // Reset during the 4th bit of pixel 10's high byte.
    rx_q.delete(); exp_q.delete(); fb_cyc.delete();
    enable = 1'b1;
    t = 0;
    while (!(rx_q.size() == 26 && rx_bits == 3 && !sclk && !cs_n) && t < FRAME_LEN) begin
      @(posedge clk); #2; t++;
    end
    check("rst_wait_bit4", rx_q.size() == 26 && rx_bits == 3 && !sclk, 1);
    check("rst_mid_index", pixel_index, 10);
    rst_n = 1'b0;
    #1;
    check("rst_mid_cs_n", cs_n, 1);
    check("rst_mid_sclk", sclk, 1);
    check("rst_mid_sdin", sdin, 0);
    check("rst_mid_d_cn", d_cn, 0);
    check("rst_mid_index0", pixel_index, 0);
    fb_cyc.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    while (fb_cyc.size() < 1 && t < 50) begin @(negedge clk); t++; end
    check("rst_post_frame_begin", fb_cyc.size(), 1);
    enable = 1'b0;
    t = 0;
    while (rx_q.size() < 27 && t < 400) begin @(negedge clk); t++; end
    check("rst_post_first_byte", (rx_q.size() >= 27) ? rx_q[26] : 9'bx, 9'h015);
    t = 0;
    while (!(cs_n && rx_q.size() >= 26 + FRAME_BYTES) && t < FRAME_LEN + 200) begin
      @(negedge clk); t++;
    end
    check("rst_post_wait_end", cs_n, 1);
    repeat (50) @(negedge clk);
    append_frame(26);
    append_frame(FRAME_BYTES);
    compare_stream("rst");
    check("rst_frame_begin_cnt", fb_cyc.size(), 1);

    check("sdin_stable_errs", sdin_err, 0);
    check("sclk_phase_errs", phase_err, 0);
    check("d_cn_byte_errs", dcn_err, 0);
    check("index_range_errs", idx_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
